// File: rtl/synth_pkg.sv
// Shared types and defaults for the polyphonic voice allocator.
package synth_pkg;

  localparam int NUM_VOICES_DEFAULT = 8;
  localparam int NOTE_W_DEFAULT     = 5;
  localparam int AGE_W_DEFAULT      = 8;

  typedef logic [NOTE_W_DEFAULT-1:0] note_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } alloc_state_t;

endpackage

// File: rtl/voice_allocator_if.sv
// Note event channel from the PS/2 note decoder into the voice allocator.
interface voice_allocator_if #(
  parameter int NOTE_W = 5
);

  logic              ev_valid;
  logic              ev_ready;
  logic              ev_on;
  logic [NOTE_W-1:0] ev_note;

  modport master (
    output ev_valid,
    output ev_on,
    output ev_note,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_on,
    input  ev_note,
    output ev_ready
  );

endinterface

// File: rtl/voice_age_tracker.sv
// Per-voice saturating age counters; a touched voice restarts at zero while the rest grow older.
module voice_age_tracker #(
  parameter int NUM_VOICES = 8,
  parameter int AGE_W      = 8,
  parameter int IDX_W      = $clog2(NUM_VOICES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             touch,
  input  logic [IDX_W-1:0] touch_idx,
  input  logic [IDX_W-1:0] scan_idx,
  input  logic [AGE_W-1:0] cmp_age,
  output logic [AGE_W-1:0] scan_age,
  output logic             scan_older
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [AGE_W-1:0] age_q [NUM_VOICES];
  logic [AGE_W-1:0] age_d [NUM_VOICES];

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      age_d[v] = age_q[v];
      if (touch) begin
        if (IDX_W'(v) == touch_idx) begin
          age_d[v] = '0;
        end else if (age_q[v] != AGE_MAX) begin
          age_d[v] = age_q[v] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        age_q[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        age_q[v] <= age_d[v];
      end
    end
  end

  // Strictly greater, so equal ages keep the earlier (lower-index) candidate.
  assign scan_age   = age_q[scan_idx];
  assign scan_older = (scan_age > cmp_age);

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: walks the voices one per cycle, then commits a note-on/off with
// retrigger, free-voice, releasing-voice and oldest-gated-steal priority.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEFAULT,
  parameter int NOTE_W     = NOTE_W_DEFAULT,
  parameter int AGE_W      = AGE_W_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  voice_allocator_if.slave             ev,
  input  logic [NUM_VOICES-1:0]        voice_idle,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_trig,
  output logic                         steal
);

  localparam int               IDX_W    = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  alloc_state_t state_q, state_d;
  logic                         run_q;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         ev_on_q, ev_on_d;
  logic [NOTE_W-1:0]            ev_note_q, ev_note_d;
  logic [NUM_VOICES-1:0]        gate_q, gate_d;
  logic [NUM_VOICES*NOTE_W-1:0] note_q, note_d;
  logic [NUM_VOICES-1:0]        trig_q, trig_d;
  logic                         steal_q, steal_d;

  logic             same_found_q, same_found_d;
  logic [IDX_W-1:0] same_idx_q, same_idx_d;
  logic             free_found_q, free_found_d;
  logic [IDX_W-1:0] free_idx_q, free_idx_d;
  logic             rel_found_q, rel_found_d;
  logic [IDX_W-1:0] rel_idx_q, rel_idx_d;
  logic [AGE_W-1:0] rel_age_q, rel_age_d;
  logic             gat_found_q, gat_found_d;
  logic [IDX_W-1:0] gat_idx_q, gat_idx_d;
  logic [AGE_W-1:0] gat_age_q, gat_age_d;

  logic              ready;
  logic              cur_gate;
  logic              cur_idle;
  logic [NOTE_W-1:0] cur_note;
  logic [AGE_W-1:0]  cmp_age;
  logic [AGE_W-1:0]  scan_age;
  logic              scan_older;
  logic              touch;
  logic [IDX_W-1:0]  chosen_idx;
  logic              chosen_steal;

  // run_q holds ev_ready low until the first edge after reset release.
  assign ready       = run_q && (state_q == IDLE);
  assign ev.ev_ready = ready;

  assign cur_gate = gate_q[idx_q];
  assign cur_idle = voice_idle[idx_q];
  assign cur_note = note_q[idx_q*NOTE_W +: NOTE_W];
  assign cmp_age  = cur_gate ? gat_age_q : rel_age_q;

  voice_age_tracker #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W),
    .IDX_W      (IDX_W)
  ) u_age (
    .clk        (clk),
    .reset_n    (reset_n),
    .touch      (touch),
    .touch_idx  (chosen_idx),
    .scan_idx   (idx_q),
    .cmp_age    (cmp_age),
    .scan_age   (scan_age),
    .scan_older (scan_older)
  );

  always_comb begin
    chosen_idx   = gat_idx_q;
    chosen_steal = 1'b0;
    if (same_found_q) begin
      chosen_idx = same_idx_q;
    end else if (free_found_q) begin
      chosen_idx = free_idx_q;
    end else if (rel_found_q) begin
      chosen_idx = rel_idx_q;
    end else begin
      chosen_steal = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ev_on_d      = ev_on_q;
    ev_note_d    = ev_note_q;
    gate_d       = gate_q;
    note_d       = note_q;
    trig_d       = '0;
    steal_d      = 1'b0;
    touch        = 1'b0;
    same_found_d = same_found_q;
    same_idx_d   = same_idx_q;
    free_found_d = free_found_q;
    free_idx_d   = free_idx_q;
    rel_found_d  = rel_found_q;
    rel_idx_d    = rel_idx_q;
    rel_age_d    = rel_age_q;
    gat_found_d  = gat_found_q;
    gat_idx_d    = gat_idx_q;
    gat_age_d    = gat_age_q;

    unique case (state_q)
      IDLE: begin
        if (ev.ev_valid && ready) begin
          ev_on_d      = ev.ev_on;
          ev_note_d    = ev.ev_note;
          idx_d        = '0;
          same_found_d = 1'b0;
          free_found_d = 1'b0;
          rel_found_d  = 1'b0;
          rel_age_d    = '0;
          gat_found_d  = 1'b0;
          gat_age_d    = '0;
          state_d      = SCAN;
        end
      end

      SCAN: begin
        if (cur_gate) begin
          if (!same_found_q && (cur_note == ev_note_q)) begin
            same_found_d = 1'b1;
            same_idx_d   = idx_q;
          end
          if (!gat_found_q || scan_older) begin
            gat_found_d = 1'b1;
            gat_idx_d   = idx_q;
            gat_age_d   = scan_age;
          end
        end else if (cur_idle) begin
          if (!free_found_q) begin
            free_found_d = 1'b1;
            free_idx_d   = idx_q;
          end
        end else if (!rel_found_q || scan_older) begin
          rel_found_d = 1'b1;
          rel_idx_d   = idx_q;
          rel_age_d   = scan_age;
        end

        if (idx_q == LAST_IDX) begin
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      COMMIT: begin
        if (ev_on_q) begin
          gate_d[chosen_idx]                     = 1'b1;
          note_d[chosen_idx*NOTE_W +: NOTE_W]    = ev_note_q;
          trig_d[chosen_idx]                     = 1'b1;
          steal_d                                = chosen_steal;
          touch                                  = 1'b1;
        end else begin
          // Note stays latched on released voices so the release tail keeps its pitch.
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (gate_q[v] && (note_q[v*NOTE_W +: NOTE_W] == ev_note_q)) begin
              gate_d[v] = 1'b0;
            end
          end
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      run_q        <= 1'b0;
      idx_q        <= '0;
      ev_on_q      <= 1'b0;
      ev_note_q    <= '0;
      gate_q       <= '0;
      note_q       <= '0;
      trig_q       <= '0;
      steal_q      <= 1'b0;
      same_found_q <= 1'b0;
      same_idx_q   <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      rel_found_q  <= 1'b0;
      rel_idx_q    <= '0;
      rel_age_q    <= '0;
      gat_found_q  <= 1'b0;
      gat_idx_q    <= '0;
      gat_age_q    <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= 1'b1;
      idx_q        <= idx_d;
      ev_on_q      <= ev_on_d;
      ev_note_q    <= ev_note_d;
      gate_q       <= gate_d;
      note_q       <= note_d;
      trig_q       <= trig_d;
      steal_q      <= steal_d;
      same_found_q <= same_found_d;
      same_idx_q   <= same_idx_d;
      free_found_q <= free_found_d;
      free_idx_q   <= free_idx_d;
      rel_found_q  <= rel_found_d;
      rel_idx_q    <= rel_idx_d;
      rel_age_q    <= rel_age_d;
      gat_found_q  <= gat_found_d;
      gat_idx_q    <= gat_idx_d;
      gat_age_q    <= gat_age_d;
    end
  end

  assign voice_gate = gate_q;
  assign voice_note = note_q;
  assign voice_trig = trig_q;
  assign steal      = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: latency, allocation priority, stealing, handshake and reset abort.
module tb_voice_allocator;
  import synth_pkg::*;

  localparam int NV = 8;
  localparam int NW = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NV-1:0]     voice_idle;
  logic [NV-1:0]     voice_gate;
  logic [NV*NW-1:0]  voice_note;
  logic [NV-1:0]     voice_trig;
  logic              steal;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  voice_allocator_if #(.NOTE_W(NW)) ev_if ();

  voice_allocator #(
    .NUM_VOICES (NV),
    .NOTE_W     (NW),
    .AGE_W      (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ev         (ev_if),
    .voice_idle (voice_idle),
    .voice_gate (voice_gate),
    .voice_note (voice_note),
    .voice_trig (voice_trig),
    .steal      (steal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [NW-1:0] note_of(input int v);
    return voice_note[v*NW +: NW];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one event and waits (bounded) for it to be accepted; ev_valid is left high.
  task automatic applyStimulus(input logic on, input logic [NW-1:0] note, output int acc_cyc);
    ev_if.ev_on    = on;
    ev_if.ev_note  = note;
    ev_if.ev_valid = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ev_if.ev_ready) begin
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout observed=no_accept expected=accept note=%0d", note);
    end
  endtask

  task automatic send_and_commit(input logic on, input logic [NW-1:0] note);
    int acc;
    applyStimulus(on, note, acc);
    ev_if.ev_valid = 1'b0;
    repeat (NV + 1) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a0, a1, a2;
    logic [NV*NW-1:0] notes_before;

    ev_if.ev_valid = 1'b0;
    ev_if.ev_on    = 1'b0;
    ev_if.ev_note  = '0;
    voice_idle     = '1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_gate",  64'(voice_gate), 64'h0);
    checkOutput("rst_note",  64'(voice_note), 64'h0);
    checkOutput("rst_trig",  64'(voice_trig), 64'h0);
    checkOutput("rst_steal", 64'(steal), 64'h0);
    checkOutput("rst_ready", 64'(ev_if.ev_ready), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("ready_before_edge", 64'(ev_if.ev_ready), 64'h0);
    @(posedge clk);
    #1;
    checkOutput("ready_after_edge", 64'(ev_if.ev_ready), 64'h1);

    // Single note-on, latency check.
    applyStimulus(1'b1, 5'd10, a0);
    ev_if.ev_valid = 1'b0;
    repeat (NV) @(posedge clk);
    #1;
    checkOutput("t1_gate_in_commit",  64'(voice_gate), 64'h0);
    checkOutput("t1_ready_in_commit", 64'(ev_if.ev_ready), 64'h0);
    @(posedge clk);
    #1;
    checkOutput("t1_gate",  64'(voice_gate), 64'h01);
    checkOutput("t1_note0", 64'(note_of(0)), 64'd10);
    checkOutput("t1_trig",  64'(voice_trig), 64'h01);
    checkOutput("t1_steal", 64'(steal), 64'h0);
    checkOutput("t1_ready", 64'(ev_if.ev_ready), 64'h1);
    @(posedge clk);
    #1;
    checkOutput("t1_trig_clear", 64'(voice_trig), 64'h0);

    // Fill all voices, then steal the oldest.
    do_reset();
    voice_idle = '1;
    for (int n = 1; n <= NV; n++) begin
      send_and_commit(1'b1, NW'(n));
      voice_idle[n-1] = 1'b0;
    end
    checkOutput("t2_gate_full", 64'(voice_gate), 64'hFF);
    checkOutput("t2_note7",     64'(note_of(7)), 64'd8);
    send_and_commit(1'b1, 5'd20);
    checkOutput("t2_steal_trig",  64'(voice_trig), 64'h01);
    checkOutput("t2_steal",       64'(steal), 64'h1);
    checkOutput("t2_steal_note0", 64'(note_of(0)), 64'd20);
    checkOutput("t2_steal_note1", 64'(note_of(1)), 64'd2);
    checkOutput("t2_gate_after",  64'(voice_gate), 64'hFF);
    @(posedge clk);
    #1;
    checkOutput("t2_steal_clear", 64'(steal), 64'h0);

    // Free idle voice preferred over a releasing one.
    do_reset();
    voice_idle = '1;
    send_and_commit(1'b1, 5'd3);
    send_and_commit(1'b1, 5'd4);
    voice_idle[1:0] = 2'b00;
    send_and_commit(1'b0, 5'd3);
    checkOutput("t3_off_gate", 64'(voice_gate), 64'h02);
    checkOutput("t3_off_trig", 64'(voice_trig), 64'h0);
    checkOutput("t3_off_note", 64'(note_of(0)), 64'd3);
    send_and_commit(1'b1, 5'd9);
    checkOutput("t3_gate",  64'(voice_gate), 64'h06);
    checkOutput("t3_note2", 64'(note_of(2)), 64'd9);
    checkOutput("t3_trig",  64'(voice_trig), 64'h04);

    // Retrigger of an already gated note.
    send_and_commit(1'b1, 5'd5);
    checkOutput("t4_first_trig", 64'(voice_trig), 64'h08);
    voice_idle[3:1] = 3'b000;
    notes_before = voice_note;
    send_and_commit(1'b1, 5'd5);
    checkOutput("t4_retrig",       64'(voice_trig), 64'h08);
    checkOutput("t4_retrig_gate",  64'(voice_gate), 64'h0E);
    checkOutput("t4_retrig_steal", 64'(steal), 64'h0);
    checkOutput("t4_retrig_notes", 64'(voice_note), 64'(notes_before));

    // Back-to-back events with ev_valid held high.
    applyStimulus(1'b1, 5'd11, a0);
    applyStimulus(1'b1, 5'd12, a1);
    applyStimulus(1'b0, 5'd5, a2);
    ev_if.ev_valid = 1'b0;
    checkOutput("t5_spacing1", 64'(a1 - a0), 64'd10);
    checkOutput("t5_spacing2", 64'(a2 - a1), 64'd10);
    repeat (NV + 1) @(posedge clk);
    #1;
    checkOutput("t5_gate",  64'(voice_gate), 64'h36);
    checkOutput("t5_note4", 64'(note_of(4)), 64'd11);
    checkOutput("t5_note5", 64'(note_of(5)), 64'd12);

    // Reset mid-scan aborts the event.
    applyStimulus(1'b1, 5'd7, a0);
    ev_if.ev_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_gate",  64'(voice_gate), 64'h0);
    checkOutput("t6_note",  64'(voice_note), 64'h0);
    checkOutput("t6_ready", 64'(ev_if.ev_ready), 64'h0);
    checkOutput("t6_trig",  64'(voice_trig), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t6_ready_after", 64'(ev_if.ev_ready), 64'h1);
    repeat (NV + 2) @(posedge clk);
    #1;
    checkOutput("t6_gate_after", 64'(voice_gate), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
